// File: rtl/mavg_pkg.sv
// Shared helpers for the cascaded moving-average smoothing filter.
// Holds the width helper, signed saturation and legal parameter ranges.
package mavg_pkg;

  localparam int unsigned Log2lMin = 1;
  localparam int unsigned Log2lMax = 5;
  localparam int unsigned NMin     = 1;
  localparam int unsigned NMax     = 4;

  // Width of the running sum after k sections (each section adds log2l bits of growth).
  function automatic int unsigned sum_w(input int unsigned w, input int unsigned k,
                                        input int unsigned log2l);
    return w + k * log2l;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/mavg_stage.sv
// One recursive running-sum section: s <= s + x - x[n-L], with an L-entry circular delay line.
// The write pointer is supplied by the parent so all sections stay aligned.
module mavg_stage
  import mavg_pkg::*;
#(
  parameter int unsigned Iw    = 10,
  parameter int unsigned Log2l = 2,
  localparam int unsigned Sw   = sum_w(Iw, 1, Log2l)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [Log2l-1:0]     wr_ptr,
  input  logic signed [Iw-1:0] x,
  output logic signed [Sw-1:0] s
);

  localparam int L = 1 << Log2l;

  logic signed [Iw-1:0] dl_q [L];
  logic signed [Iw-1:0] dl_d [L];
  logic signed [Sw-1:0] s_q, s_d;

  // The slot under the write pointer holds the sample from L strobes ago.
  always_comb begin
    dl_d = dl_q;
    s_d  = s_q;
    if (clr) begin
      for (int i = 0; i < L; i++) begin
        dl_d[i] = '0;
      end
      s_d = '0;
    end else if (en) begin
      s_d            = s_q + Sw'(x) - Sw'(dl_q[wr_ptr]);
      dl_d[wr_ptr]   = x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      for (int i = 0; i < L; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      s_q  <= s_d;
      dl_q <= dl_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/mavg_interp.sv
// Cascaded moving-average image-rejection filter for a zero-stuffed/held sample stream.
// N full-precision running-sum sections followed by a shift, saturate and output register.
module mavg_interp
  import mavg_pkg::*;
#(
  parameter int unsigned W     = 10,
  parameter int unsigned LOG2L = 2,
  parameter int unsigned N     = 2,
  parameter int unsigned GSH   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic signed [W-1:0] in,
  output logic signed [W-1:0] out,
  output logic                valid
);

  localparam int unsigned L    = 1 << LOG2L;
  localparam int unsigned NL   = N * L;
  localparam int unsigned CntW = $clog2(NL + 1);
  localparam int unsigned SwN  = sum_w(W, N, LOG2L);
  localparam int unsigned Sh   = N * LOG2L - GSH;

  if (LOG2L < Log2lMin || LOG2L > Log2lMax) begin : gen_bad_log2l
    $error("mavg_interp: LOG2L out of range");
  end
  if (N < NMin || N > NMax) begin : gen_bad_n
    $error("mavg_interp: N out of range");
  end
  if (GSH > LOG2L * N) begin : gen_bad_gsh
    $error("mavg_interp: GSH out of range");
  end

  logic [LOG2L-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic signed [W-1:0] out_q, out_d;
  logic signed [SwN-1:0] s_n;
  logic signed [SwN-1:0] t;

  for (genvar k = 0; k < N; k++) begin : gen_stage
    localparam int unsigned Iw = sum_w(W, k, LOG2L);
    logic signed [Iw-1:0]       x_k;
    logic signed [Iw+LOG2L-1:0] s_k;

    if (k == 0) begin : gen_first
      assign x_k = in;
    end else begin : gen_chain
      assign x_k = gen_stage[k-1].s_k;
    end

    mavg_stage #(
      .Iw    (Iw),
      .Log2l (LOG2L)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (en),
      .wr_ptr (wr_ptr_q),
      .x      (x_k),
      .s      (s_k)
    );
  end

  assign s_n   = gen_stage[N-1].s_k;
  assign valid = (cnt_q == CntW'(NL));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    t        = s_n >>> Sh;
    if (clr) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
      out_d    = '0;
    end else if (en) begin
      wr_ptr_d = wr_ptr_q + LOG2L'(1);
      if (!valid) begin
        cnt_d = cnt_q + CntW'(1);
      end
      out_d = W'(sat(64'(t), W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mavg_interp.sv
// Scoreboard bench: two filters (GSH=0 and GSH=2) share the stimulus; a convolution model
// with the hand-derived 1,2,3,4,3,2,1 impulse response predicts every clock's outputs.
module tb_mavg_interp;

  typedef struct {
    longint o0;
    longint o2;
    longint v;
  } exp_t;

  localparam int H [7] = '{1, 2, 3, 4, 3, 2, 1};

  logic clk;
  logic rst;
  logic en;
  logic clr;
  logic signed [9:0] din;
  logic signed [9:0] out0, out2;
  logic valid0, valid2;

  int n_vec = 0;
  int n_bad = 0;

  exp_t   sb [$];
  longint hist [$];
  int     strobes = 0;
  longint e_o0 = 0, e_o2 = 0, e_v = 0;

  mavg_interp #(.W(10), .LOG2L(2), .N(2), .GSH(0)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .in    (din),
    .out   (out0),
    .valid (valid0)
  );

  mavg_interp #(.W(10), .LOG2L(2), .N(2), .GSH(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .in    (din),
    .out   (out2),
    .valid (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output on strobe n = sum_j H[j] * x[n-2-j], scaled by 2^(gsh-4) with floor, then clamped.
  function automatic longint model_out(input int gsh);
    longint acc;
    int n;
    int idx;
    acc = 0;
    n = hist.size() - 1;
    for (int j = 0; j < 7; j++) begin
      idx = n - 2 - j;
      if (idx >= 0) acc += longint'(H[j]) * hist[idx];
    end
    acc = acc >>> (4 - gsh);
    if (acc > 511) acc = 511;
    if (acc < -512) acc = -512;
    return acc;
  endfunction

  task automatic model_reset();
    hist.delete();
    strobes = 0;
    e_o0 = 0;
    e_o2 = 0;
    e_v  = 0;
  endtask

  task automatic step(input logic e, input logic c, input int x);
    exp_t ex;
    @(negedge clk);
    rst = 1'b0;
    en  = e;
    clr = c;
    din = 10'(x);
    if (c) begin
      model_reset();
    end else if (e) begin
      hist.push_back(longint'(x));
      strobes++;
      e_o0 = model_out(0);
      e_o2 = model_out(2);
    end
    e_v = (strobes >= 8) ? 1 : 0;
    ex.o0 = e_o0;
    ex.o2 = e_o2;
    ex.v  = e_v;
    sb.push_back(ex);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out0", longint'(out0), 0);
    check("async_rst_valid0", longint'(valid0), 0);
    check("async_rst_out2", longint'(out2), 0);
    check("async_rst_valid2", longint'(valid2), 0);
    model_reset();
  endtask

  always @(posedge clk) begin : monitor
    exp_t ex;
    if (!rst) begin
      #1;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_underflow: got empty queue, expected an entry (t=%0t)", $time);
      end else begin
        ex = sb.pop_front();
        check("out_gsh0", longint'(out0), ex.o0);
        check("out_gsh2", longint'(out2), ex.o2);
        check("valid_gsh0", longint'(valid0), ex.v);
        check("valid_gsh2", longint'(valid2), ex.v);
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    din = '0;
    #2;
    check("reset_out0", longint'(out0), 0);
    check("reset_valid0", longint'(valid0), 0);
    check("reset_out2", longint'(out2), 0);
    check("reset_valid2", longint'(valid2), 0);

    // Impulse at full rate: expect 16,32,48,64,48,32,16 from the GSH=0 filter.
    step(1'b1, 1'b0, 256);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 0);

    // Step input with en every third cycle; valid rises on the 8th strobe.
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 100);
      step(1'b0, 1'b0, 100);
      step(1'b1, 1'b0, 100);
    end

    // Saturation on the GSH=2 filter, then full-scale extremes.
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 200);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, -300);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 511);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, -512);

    // Flush coincident with a strobe: that sample must be discarded.
    step(1'b1, 1'b0, 300);
    step(1'b1, 1'b0, -150);
    step(1'b1, 1'b1, 77);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, (i == 0) ? 40 : 0);

    // Asynchronous reset while the output is non-zero, then the impulse again.
    step(1'b1, 1'b0, 256);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    async_reset();
    step(1'b1, 1'b0, 256);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 0);

    // Random strobe density and data, including back-to-back strobes.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 1'b0, int'($urandom_range(0, 1023)) - 512);
    end

    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    @(negedge clk);
    check("sb_drained", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
